// File: rtl/irrigation_scheduler.sv
// Irrigation sequencing controller: sprinkler/drip valve timing, soak pause,
// hysteretic tank refill and alarm-driven FAULT hold-off.
module irrigation_scheduler #(
  parameter int unsigned TW         = 8,
  parameter int unsigned SPRINKLE_S = 30,
  parameter int unsigned DRIP_S     = 60,
  parameter int unsigned SOAK_S     = 20,
  parameter int unsigned CLEAR_S    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_1s,
  input  logic          soil_dry,
  input  logic          air_dry,
  input  logic          temp_hot,
  input  logic          lvl_h,
  input  logic          lvl_m,
  input  logic          lvl_l,
  input  logic          alarm,
  output logic          va,
  output logic          vg,
  output logic          fill,
  output logic [2:0]    state,
  output logic [TW-1:0] remaining,
  output logic [7:0]    runs
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPRINKLE = 3'd1,
    DRIP     = 3'd2,
    SOAK     = 3'd3,
    FAULT    = 3'd4
  } stateT;

  // Run lengths truncated to the timer width; a zero length behaves as one tick.
  localparam logic [TW-1:0] sprinkleLoad = (TW'(SPRINKLE_S) == '0) ? TW'(1) : TW'(SPRINKLE_S);
  localparam logic [TW-1:0] dripLoad     = (TW'(DRIP_S) == '0)     ? TW'(1) : TW'(DRIP_S);
  localparam logic [TW-1:0] soakLoad     = (TW'(SOAK_S) == '0)     ? TW'(1) : TW'(SOAK_S);

  localparam int unsigned   CW        = (CLEAR_S < 2) ? 1 : $clog2(CLEAR_S + 1);
  localparam logic [CW-1:0] clearLast = CW'((CLEAR_S > 0) ? CLEAR_S - 1 : 0);

  stateT         curState;
  logic [CW-1:0] clearCnt;
  logic          entry;
  logic          tickLive;

  // The first cycle of a timed state never consumes a tick.
  assign tickLive = tick_1s && !entry;

  assign state = curState;
  assign va    = (curState == SPRINKLE);
  assign vg    = (curState == DRIP);

  always_ff @(posedge clk) begin
    if (reset) begin
      curState  <= IDLE;
      remaining <= '0;
      runs      <= '0;
      fill      <= 1'b0;
      clearCnt  <= '0;
      entry     <= 1'b0;
    end else begin
      entry <= 1'b0;

      // Refill hysteresis: high probe clears, a missing low/mid probe sets.
      if (alarm || curState == FAULT) fill <= 1'b0;
      else if (lvl_h)                 fill <= 1'b0;
      else if (!lvl_l || !lvl_m)      fill <= 1'b1;

      if (alarm) begin
        curState  <= FAULT;
        remaining <= '0;
        clearCnt  <= '0;
      end else begin
        case (curState)
          IDLE: begin
            if (lvl_m && soil_dry) begin
              curState  <= SPRINKLE;
              remaining <= sprinkleLoad;
              entry     <= 1'b1;
            end else if (lvl_m && (air_dry || temp_hot)) begin
              curState  <= DRIP;
              remaining <= dripLoad;
              entry     <= 1'b1;
            end
          end
          SPRINKLE, DRIP: begin
            if (!lvl_m) begin
              curState  <= SOAK;
              remaining <= soakLoad;
              entry     <= 1'b1;
            end else if (tickLive) begin
              if (remaining == TW'(1)) begin
                curState  <= SOAK;
                remaining <= soakLoad;
                entry     <= 1'b1;
                runs      <= runs + 8'd1;
              end else begin
                remaining <= remaining - TW'(1);
              end
            end
          end
          SOAK: begin
            if (tickLive) begin
              if (remaining == TW'(1)) begin
                curState  <= IDLE;
                remaining <= '0;
              end else begin
                remaining <= remaining - TW'(1);
              end
            end
          end
          FAULT: begin
            if (tick_1s) begin
              if (clearCnt == clearLast) begin
                curState  <= SOAK;
                remaining <= soakLoad;
                entry     <= 1'b1;
                clearCnt  <= '0;
              end else begin
                clearCnt <= clearCnt + CW'(1);
              end
            end
          end
          default: begin
            curState  <= IDLE;
            remaining <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: two instances (short timers and
// zero-length timers) driven from shared inputs, checked at the falling edge.
module tb_irrigation_scheduler;

  logic clk = 1'b0;
  logic reset, tick_1s, soil_dry, air_dry, temp_hot, lvl_h, lvl_m, lvl_l, alarm;

  logic       va, vg, fill;
  logic [2:0] state;
  logic [7:0] remaining, runs;

  logic       va0, vg0, fill0;
  logic [2:0] state0;
  logic [7:0] remaining0, runs0;

  irrigation_scheduler #(.TW(8), .SPRINKLE_S(3), .DRIP_S(4), .SOAK_S(2), .CLEAR_S(2)) dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .soil_dry(soil_dry), .air_dry(air_dry),
    .temp_hot(temp_hot), .lvl_h(lvl_h), .lvl_m(lvl_m), .lvl_l(lvl_l), .alarm(alarm),
    .va(va), .vg(vg), .fill(fill), .state(state), .remaining(remaining), .runs(runs)
  );

  irrigation_scheduler #(.TW(8), .SPRINKLE_S(0), .DRIP_S(0), .SOAK_S(0), .CLEAR_S(2)) dut0 (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .soil_dry(soil_dry), .air_dry(air_dry),
    .temp_hot(temp_hot), .lvl_h(lvl_h), .lvl_m(lvl_m), .lvl_l(lvl_l), .alarm(alarm),
    .va(va0), .vg(vg0), .fill(fill0), .state(state0), .remaining(remaining0), .runs(runs0)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    bit         d;
    logic [2:0] st;
    logic [7:0] rem;
    logic       a;
    logic       g;
    logic       f;
    logic [7:0] r;
  } expT;

  expT sbq[$];
  expT e;
  int  errors = 0;
  int  checks = 0;
  logic [2:0] oSt;
  logic [7:0] oRem, oRuns;
  logic       oA, oG, oF;

  // Monitor: valve exclusivity every cycle, then drain pending expectations.
  always @(negedge clk) begin
    checks++;
    if ((va && vg) || (va0 && vg0)) begin
      errors++;
      $display("FAIL valve_exclusive t=%0t va=%b vg=%b va0=%b vg0=%b required never both", $time, va, vg, va0, vg0);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.d) begin
        oSt = state0; oRem = remaining0; oA = va0; oG = vg0; oF = fill0; oRuns = runs0;
      end else begin
        oSt = state; oRem = remaining; oA = va; oG = vg; oF = fill; oRuns = runs;
      end
      checks++;
      if (oSt !== e.st || oRem !== e.rem || oA !== e.a || oG !== e.g || oF !== e.f || oRuns !== e.r) begin
        errors++;
        $display("FAIL %s got st=%0d rem=%0d va=%b vg=%b fill=%b runs=%0d expected st=%0d rem=%0d va=%b vg=%b fill=%b runs=%0d",
                 e.nm, oSt, oRem, oA, oG, oF, oRuns, e.st, e.rem, e.a, e.g, e.f, e.r);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tk();
    tick_1s = 1'b1;
    cyc();
    tick_1s = 1'b0;
  endtask

  task automatic chk(input string nm, input bit d, input logic [2:0] st, input logic [7:0] rem,
                     input logic a, input logic g, input logic f, input logic [7:0] r);
    expT x;
    x.nm = nm; x.d = d; x.st = st; x.rem = rem; x.a = a; x.g = g; x.f = f; x.r = r;
    sbq.push_back(x);
  endtask

  initial begin
    reset = 1'b1; tick_1s = 1'b0; soil_dry = 1'b0; air_dry = 1'b0; temp_hot = 1'b0;
    lvl_h = 1'b1; lvl_m = 1'b1; lvl_l = 1'b1; alarm = 1'b0;
    cyc(); cyc();
    chk("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset0", 1, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Sprinkle run of 3 ticks then soak of 2
    soil_dry = 1'b1; cyc();
    chk("spr_entry", 0, 1, 3, 1, 0, 0, 0);
    soil_dry = 1'b0; tk();
    chk("spr_entry_tick_ignored", 0, 1, 3, 1, 0, 0, 0);
    tk(); chk("spr_rem2", 0, 1, 2, 1, 0, 0, 0);
    tk(); chk("spr_rem1", 0, 1, 1, 1, 0, 0, 0);
    tk(); chk("spr_expire_soak", 0, 3, 2, 0, 0, 0, 1);
    cyc(); tk(); chk("soak_rem1", 0, 3, 1, 0, 0, 0, 1);
    tk(); chk("soak_to_idle", 0, 0, 0, 0, 0, 0, 1);

    // Drip run of 4 ticks
    temp_hot = 1'b1; cyc();
    chk("drip_entry", 0, 2, 4, 0, 1, 0, 1);
    temp_hot = 1'b0; cyc();
    tk(); tk(); tk(); chk("drip_rem1", 0, 2, 1, 0, 1, 0, 1);
    tk(); chk("drip_expire", 0, 3, 2, 0, 0, 0, 2);
    cyc(); tk(); tk(); chk("drip_soak_idle", 0, 0, 0, 0, 0, 0, 2);

    // Both conditions: sprinkle wins; then level abort and refill hysteresis
    soil_dry = 1'b1; temp_hot = 1'b1; cyc();
    chk("spr_precedence", 0, 1, 3, 1, 0, 0, 2);
    soil_dry = 1'b0; temp_hot = 1'b0; cyc(); tk();
    chk("spr_before_abort", 0, 1, 2, 1, 0, 0, 2);
    lvl_m = 1'b0; lvl_h = 1'b0; cyc();
    chk("abort_soak_fill_set", 0, 3, 2, 0, 0, 1, 2);
    lvl_m = 1'b1; cyc();
    chk("fill_hold", 0, 3, 2, 0, 0, 1, 2);
    lvl_h = 1'b1; cyc();
    chk("fill_clear", 0, 3, 2, 0, 0, 0, 2);
    tk(); tk(); chk("abort_idle", 0, 0, 0, 0, 0, 0, 2);

    // Alarm mid-drip, then clear-counter behaviour in FAULT
    lvl_h = 1'b0; lvl_l = 1'b0; temp_hot = 1'b1; cyc();
    chk("drip2_entry_fill", 0, 2, 4, 0, 1, 1, 2);
    temp_hot = 1'b0; cyc(); tk(); tk();
    chk("drip2_rem2", 0, 2, 2, 0, 1, 1, 2);
    alarm = 1'b1; cyc();
    chk("alarm_fault", 0, 4, 0, 0, 0, 0, 2);
    alarm = 1'b0; tk(); chk("fault_one_clear", 0, 4, 0, 0, 0, 0, 2);
    alarm = 1'b1; cyc(); alarm = 1'b0; tk();
    chk("fault_counter_reset", 0, 4, 0, 0, 0, 0, 2);
    cyc(); lvl_h = 1'b1; lvl_l = 1'b1; tk();
    chk("fault_exit_soak", 0, 3, 2, 0, 0, 0, 2);
    cyc(); tk(); tk(); chk("fault_soak_idle", 0, 0, 0, 0, 0, 0, 2);

    // Reset mid-drip and mid-fault; entry tick ignored afterwards
    temp_hot = 1'b1; cyc(); temp_hot = 1'b0; cyc(); tk();
    chk("drip3_rem3", 0, 2, 3, 0, 1, 0, 2);
    reset = 1'b1; cyc();
    chk("reset_mid_drip", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0; alarm = 1'b1; cyc();
    chk("fault_from_idle", 0, 4, 0, 0, 0, 0, 0);
    reset = 1'b1; cyc();
    chk("reset_mid_fault", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0; alarm = 1'b0; soil_dry = 1'b1; cyc();
    chk("post_reset_spr", 0, 1, 3, 1, 0, 0, 0);
    soil_dry = 1'b0; tk();
    chk("post_reset_entry_tick", 0, 1, 3, 1, 0, 0, 0);
    tk(); chk("post_reset_rem2", 0, 1, 2, 1, 0, 0, 0);

    // Zero-length timers and runs wrap on the second instance
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("reset0_again", 1, 0, 0, 0, 0, 0, 0);
    soil_dry = 1'b1; cyc();
    chk("zero_len_entry", 1, 1, 1, 1, 0, 0, 0);
    soil_dry = 1'b0; cyc(); tk();
    chk("zero_len_one_tick", 1, 3, 1, 0, 0, 0, 1);
    cyc(); tk();
    chk("zero_len_soak_idle", 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 254; i++) begin
      soil_dry = 1'b1; cyc(); soil_dry = 1'b0; cyc(); tk(); cyc(); tk();
    end
    chk("runs_255", 1, 0, 0, 0, 0, 0, 255);
    soil_dry = 1'b1; cyc(); soil_dry = 1'b0; cyc(); tk();
    chk("runs_wrap", 1, 3, 1, 0, 0, 0, 0);
    cyc(); tk();
    chk("runs_wrap_idle", 1, 0, 0, 0, 0, 0, 0);

    cyc();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
